// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, d = a - b (mod 2^WIDTH), LSB first.
//   One full-subtractor cell and a borrow flip-flop retire one bit per clock.
//   A start/done handshake allows back-to-back operations: start is also
//   accepted in the DONE cycle, giving one result every WIDTH+1 cycles.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request; a/b sampled on the accepting edge
//   a, b   in   minuend / subtrahend (WIDTH bits)
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when d/bout/zero are updated
//   d      out  difference (WIDTH bits), held until next completion
//   bout   out  borrow out of the MSB (a < b unsigned)
//   zero   out  d == 0
//   ovf    out  signed overflow; present only with SERIAL_SUB_OVF_FLAG_EN
//
// Optional build macro: SERIAL_SUB_OVF_FLAG_EN adds the ovf output.

module serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero
`ifdef SERIAL_SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             diff_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;

`ifdef SERIAL_SUB_OVF_FLAG_EN
    // Operand sign bits are kept aside because sa/sb are shifted away.
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        diff_bit = sa[0] ^ sb[0] ^ br;
        br_nxt   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        res_nxt  = {diff_bit, res[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
`ifdef SERIAL_SUB_OVF_FLAG_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_nxt;
                    res <= res_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        d     <= res_nxt;
                        bout  <= br_nxt;
                        zero  <= (res_nxt == '0);
`ifdef SERIAL_SUB_OVF_FLAG_EN
                        ovf   <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
`endif
                    end
                end
                IDLE, DONE: begin
                    // DONE accepts start exactly like IDLE, so no idle bubble.
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_FLAG_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed and back-to-back random bench for serial_subtractor (WIDTH=4).
//   A cycle-level arithmetic model predicts busy/done/d/bout/zero; a compare
//   process checks it on every falling edge, and directed cases pin literal
//   results, latency and handshake corner cases.

module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         zero;
`ifdef SERIAL_SUB_OVF_FLAG_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .d    (d),
        .bout (bout),
        .zero (zero)
`ifdef SERIAL_SUB_OVF_FLAG_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks only "cycles left until result" and the arithmetic answer.
    int           m_rem;
    logic         m_done;
    logic [W-1:0] m_pa, m_pb, m_d;
    logic         m_bout, m_zero, m_ovf;

    function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int s;
        s = int'($signed(x)) - int'($signed(y));
        return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_pa   <= '0;
            m_pb   <= '0;
            m_d    <= '0;
            m_bout <= 1'b0;
            m_zero <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_done <= 1'b1;
                m_d    <= W'(m_pa - m_pb);
                m_bout <= (m_pa < m_pb);
                m_zero <= (m_pa == m_pb);
                m_ovf  <= signed_ovf(m_pa, m_pb);
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pa  <= a;
                m_pb  <= b;
                m_rem <= W;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("d", {28'd0, d}, {28'd0, m_d});
        chk("bout", {31'd0, bout}, {31'd0, m_bout});
        chk("zero", {31'd0, zero}, {31'd0, m_zero});
        chk("busy_and_done", {31'd0, (busy & done)}, 32'd0);
`ifdef SERIAL_SUB_OVF_FLAG_EN
        chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
    end

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge; returns 1 ns after the accepting edge with
    // operands scrambled so late changes are visible if they leaked in.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Returns at the falling edge where done is seen; cyc counts falling
    // edges since the start edge, nbusy counts those with busy high.
    task automatic wait_done(output int cyc, output int nbusy);
        bit seen;
        seen  = 0;
        cyc   = 0;
        nbusy = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cyc++;
            if (busy) nbusy++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_res(input string tag, input logic [W-1:0] ed,
                              input logic eb, input logic ez);
        chk({tag, "_d"}, {28'd0, d}, {28'd0, ed});
        chk({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    endtask

    initial begin
        int cyc, nb, ndone;

        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        expect_res("reset", 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 9 - 3: latency and busy duration
        issue(4'd9, 4'd3);
        wait_done(cyc, nb);
        chk("lat_9_3", cyc, 32'd5);
        chk("busy_cycles_9_3", nb, 32'd4);
        expect_res("r9_3", 4'd6, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_d", {28'd0, d}, 32'd6);

        // 3 - 9 wraps with borrow
        issue(4'd3, 4'd9);
        wait_done(cyc, nb);
        expect_res("r3_9", 4'hA, 1'b1, 1'b0);
        @(negedge clk);

`ifdef SERIAL_SUB_OVF_FLAG_EN
        issue(4'h7, 4'h9);
        wait_done(cyc, nb);
        chk("ovf_7_9", {31'd0, ovf}, 32'd1);
        chk("d_7_9", {28'd0, d}, 32'hE);
        @(negedge clk);
`endif

        // 15 - 15, then 0 - 1
        issue(4'd15, 4'd15);
        wait_done(cyc, nb);
        expect_res("r15_15", 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        issue(4'd0, 4'd1);
        wait_done(cyc, nb);
        expect_res("r0_1", 4'hF, 1'b1, 1'b0);
        @(negedge clk);

        // start while busy is ignored; start in DONE is accepted
        issue(4'd9, 4'd3);
        @(negedge clk);
        issue(4'd1, 4'd1);
        wait_done(cyc, nb);
        expect_res("ignored", 4'd6, 1'b0, 1'b0);
        issue(4'd5, 4'd2);
        wait_done(cyc, nb);
        chk("lat_b2b", cyc, 32'd5);
        expect_res("b2b_5_2", 4'd3, 1'b0, 1'b0);
        @(negedge clk);

        // async reset mid-operation
        issue(4'd9, 4'd3);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        expect_res("arst", 4'd0, 1'b0, 1'b0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b0;
            if (done) ndone++;
        end
        chk("no_done_after_rst", ndone, 32'd0);
        issue(4'd8, 4'd8);
        wait_done(cyc, nb);
        expect_res("r8_8", 4'd0, 1'b0, 1'b1);
        @(negedge clk);

        // 200 back-to-back random operations, checked by the model
        issue(W'($urandom), W'($urandom));
        for (int i = 0; i < 200; i++) begin
            wait_done(cyc, nb);
            chk("rand_lat", cyc, 32'd5);
            if (i < 199) issue(W'($urandom), W'($urandom));
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
